// File: rtl/hidden_layer_tdm.sv
// hidden_layer_tdm -- time-multiplexed fully-connected hidden layer.
//
// NUM_OUTPUTS neurons are evaluated by NUM_LANES shared MAC lanes over
// P = ceil(NUM_OUTPUTS/NUM_LANES) passes of NUM_INPUTS+2 cycles each.
// Weights and biases live in a local register file written over a parallel
// config port (word address n*(NUM_INPUTS+1)+i, i==NUM_INPUTS is the bias).
//
// Build option: HIDDEN_LAYER_SATURATE_EN
//   defined   -> out-of-range neuron results clamp to the WIDTH range
//   undefined -> out-of-range results wrap (low WIDTH bits)
//   overflow reports the out-of-range condition in both builds.
//
// Ports
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   cfg_we      weight/bias write strobe (accepted only in LOAD)
//   cfg_addr    weight/bias word address
//   cfg_wdata   signed weight/bias value
//   cfg_err     one-cycle pulse the cycle after a dropped write
//   ready       input accept (high in LOAD)
//   value_in    signed input sample
//   valid_in    input qualifier
//   values_out  neuron n at [n*WIDTH +: WIDTH], held between frames
//   valid_out   one-cycle pulse marking a new values_out frame
//   overflow    some neuron of the last frame was out of WIDTH range

// One MAC lane: bias preload, accumulate, then scale and range-check.
module hidden_layer_tdm_lane #(
    parameter int WIDTH     = 8,
    parameter int FRAC_BITS = 3,
    parameter int ACC_W     = 18
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    init,
    input  logic                    accum,
    input  logic signed [WIDTH-1:0] bias,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] w,
    output logic        [WIDTH-1:0] result,
    output logic                    out_of_range
);
    localparam logic signed [ACC_W-1:0] RMAX =
        {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] RMIN =
        {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   shifted;

    // Full-precision product carries 2*FRAC_BITS fraction bits, so the bias
    // is aligned by shifting it up FRAC_BITS before it seeds the accumulator.
    assign prod     = x * w;
    assign bias_ext = {{(ACC_W-WIDTH){bias[WIDTH-1]}}, bias} << FRAC_BITS;
    assign prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    assign shifted  = acc >>> FRAC_BITS;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      acc <= '0;
        else if (init)  acc <= bias_ext;
        else if (accum) acc <= acc + prod_ext;
    end

    assign out_of_range = (shifted > RMAX) || (shifted < RMIN);

`ifdef HIDDEN_LAYER_SATURATE_EN
    always_comb begin
        result = shifted[WIDTH-1:0];
        if (shifted > RMAX)      result = {1'b0, {(WIDTH-1){1'b1}}};
        else if (shifted < RMIN) result = {1'b1, {(WIDTH-1){1'b0}}};
    end
`else
    assign result = shifted[WIDTH-1:0];
`endif
endmodule

module hidden_layer_tdm #(
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_OUTPUTS = 8,
    parameter int NUM_LANES   = 2,
    parameter int WIDTH       = 8,
    parameter int FRAC_BITS   = 3,
    localparam int DEPTH      = NUM_OUTPUTS*(NUM_INPUTS+1),
    localparam int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         cfg_we,
    input  logic [ADDR_W-1:0]            cfg_addr,
    input  logic [WIDTH-1:0]             cfg_wdata,
    output logic                         cfg_err,
    output logic                         ready,
    input  logic [WIDTH-1:0]             value_in,
    input  logic                         valid_in,
    output logic [NUM_OUTPUTS*WIDTH-1:0] values_out,
    output logic                         valid_out,
    output logic                         overflow
);
    localparam int P     = (NUM_OUTPUTS + NUM_LANES - 1) / NUM_LANES;
    localparam int ACC_W = 2*WIDTH + $clog2(NUM_INPUTS+1);
    localparam int KW    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int CW    = $clog2(NUM_INPUTS+2);
    localparam int PW    = (P > 1) ? $clog2(P) : 1;

    typedef enum logic [1:0] {LOAD, COMPUTE, DONE} state_t;

    state_t                                   state;
    logic [KW-1:0]                            k;
    logic [CW-1:0]                            step;     // cycle within a pass
    logic [PW-1:0]                            pass;
    logic [WIDTH-1:0]                         wmem [DEPTH];
    logic [WIDTH-1:0]                         xr   [NUM_INPUTS];
    logic [WIDTH-1:0]                         x_cur;
    logic [NUM_OUTPUTS-1:0][WIDTH-1:0]        stage, stage_nxt;
    logic                                     frame_ovf, ovf_nxt;
    logic [NUM_LANES-1:0][WIDTH-1:0]          lane_res;
    logic [NUM_LANES-1:0]                     lane_oor;
    logic                                     lane_init, lane_acc, pass_last;
    logic                                     addr_ok, take_in;

    assign addr_ok   = {1'b0, cfg_addr} < (ADDR_W+1)'(DEPTH);
    assign take_in   = (state == LOAD) && valid_in && ready;
    assign lane_init = (state == COMPUTE) && (step == '0);
    assign lane_acc  = (state == COMPUTE) && (step != '0) &&
                       (step <= CW'(NUM_INPUTS));
    assign pass_last = (state == COMPUTE) && (step == CW'(NUM_INPUTS+1));

    // Weight/bias register file; writes only land while loading a frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int a = 0; a < DEPTH; a++) wmem[a] <= '0;
        end else if (cfg_we && addr_ok && (state == LOAD)) begin
            wmem[cfg_addr] <= cfg_wdata;
        end
    end

    // Input sample buffer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_INPUTS; i++) xr[i] <= '0;
        end else if (take_in) begin
            xr[k] <= value_in;
        end
    end

    // Sample shared by all lanes on accumulate cycle step = i+1.
    always_comb begin
        x_cur = '0;
        for (int i = 0; i < NUM_INPUTS; i++)
            if (step == CW'(i+1)) x_cur = xr[i];
    end

    for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
        logic [WIDTH-1:0] lw, lb;

        // Lane j serves neuron n = pass*NUM_LANES + j; a lane past the last
        // neuron sees zero weights and its result is never stored.
        always_comb begin
            lw = '0;
            lb = '0;
            for (int n = j; n < NUM_OUTPUTS; n += NUM_LANES) begin
                if (int'(pass) == n / NUM_LANES) begin
                    lb = wmem[n*(NUM_INPUTS+1) + NUM_INPUTS];
                    for (int i = 0; i < NUM_INPUTS; i++)
                        if (step == CW'(i+1)) lw = wmem[n*(NUM_INPUTS+1) + i];
                end
            end
        end

        hidden_layer_tdm_lane #(
            .WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W)
        ) u_lane (
            .clk(clk), .rstn(rstn), .init(lane_init), .accum(lane_acc),
            .bias(lb), .x(x_cur), .w(lw),
            .result(lane_res[j]), .out_of_range(lane_oor[j])
        );
    end

    // Staging with this pass's lane results merged in; the final pass feeds
    // values_out directly so the frame is visible while valid_out is high.
    always_comb begin
        stage_nxt = stage;
        ovf_nxt   = frame_ovf;
        if (pass_last) begin
            for (int n = 0; n < NUM_OUTPUTS; n++) begin
                if (int'(pass) == n / NUM_LANES) begin
                    stage_nxt[n] = lane_res[n % NUM_LANES];
                    ovf_nxt      = ovf_nxt | lane_oor[n % NUM_LANES];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= LOAD;
            k          <= '0;
            step       <= '0;
            pass       <= '0;
            ready      <= 1'b1;
            valid_out  <= 1'b0;
            overflow   <= 1'b0;
            cfg_err    <= 1'b0;
            values_out <= '0;
            stage      <= '0;
            frame_ovf  <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            cfg_err   <= cfg_we && ((state != LOAD) || !addr_ok);
            stage     <= stage_nxt;
            frame_ovf <= ovf_nxt;
            case (state)
                LOAD: begin
                    if (take_in) begin
                        if (k == KW'(NUM_INPUTS-1)) begin
                            k         <= '0;
                            step      <= '0;
                            pass      <= '0;
                            frame_ovf <= 1'b0;
                            ready     <= 1'b0;
                            state     <= COMPUTE;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (pass_last) begin
                        step <= '0;
                        if (pass == PW'(P-1)) begin
                            values_out <= stage_nxt;
                            overflow   <= ovf_nxt;
                            valid_out  <= 1'b1;
                            state      <= DONE;
                        end else begin
                            pass <= pass + 1'b1;
                        end
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= LOAD;
                end
                default: begin
                    ready <= 1'b1;
                    state <= LOAD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hidden_layer_tdm.sv
// Scoreboard bench for hidden_layer_tdm (NUM_INPUTS=3, NUM_OUTPUTS=5,
// NUM_LANES=2, WIDTH=8, FRAC_BITS=3 -> P=3, 15 compute cycles per frame).
module tb_hidden_layer_tdm;
    localparam int NI = 3, NO = 5, NL = 2, W = 8, FB = 3, AW = 5;
    localparam int LAT = 15;  // handshake-edge count to the DONE cycle

    logic          clk = 1'b0, rstn = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [W-1:0]  cfg_wdata = '0, value_in = '0;
    logic          valid_in = 1'b0;
    logic          cfg_err, ready, valid_out, overflow;
    logic [NO*W-1:0] values_out;

    hidden_layer_tdm #(
        .NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .NUM_LANES(NL),
        .WIDTH(W), .FRAC_BITS(FB)
    ) dut (
        .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_err(cfg_err), .ready(ready),
        .value_in(value_in), .valid_in(valid_in), .values_out(values_out),
        .valid_out(valid_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NO*W-1:0] vals;
        logic            ovf;
        int              at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int n_pass = 0, n_chk = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [NO*W-1:0] rep(input logic [W-1:0] v);
        logic [NO*W-1:0] r;
        for (int n = 0; n < NO; n++) r[n*W +: W] = v;
        return r;
    endfunction

    // Monitor: every valid_out pops one expected frame.
    always @(negedge clk) begin
        if (rstn && valid_out) begin
            if (sb.size() == 0) begin
                chk("unexpected valid_out", valid_out, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                chk("valid_out latency", cyc, mon_e.at);
                for (int n = 0; n < NO; n++)
                    chk($sformatf("neuron %0d", n), values_out[n*W +: W], mon_e.vals[n*W +: W]);
                chk("overflow", overflow, mon_e.ovf);
            end
        end
    end

    task automatic send_sample(input logic [W-1:0] v, output int hs);
        int n = 0;
        valid_in = 1'b1;
        value_in = v;
        while (!ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready) chk("ready wait timeout", ready, 1'b1);
        @(posedge clk); #1;
        hs = cyc;
    endtask

    task automatic frame(input logic [W-1:0] a, b, c, input logic push,
                         input logic [NO*W-1:0] ev, input logic eo);
        int hs;
        send_sample(a, hs);
        send_sample(b, hs);
        send_sample(c, hs);
        valid_in = 1'b0;
        if (push) begin
            exp_t e;
            e.vals = ev; e.ovf = eo; e.at = hs + LAT;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("frame completion", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic cfg_write(input int addr, input logic [W-1:0] d, input logic exp_err);
        cfg_we = 1'b1;
        cfg_addr = AW'(addr);
        cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        chk($sformatf("cfg_err addr %0d", addr), cfg_err, exp_err);
        if (exp_err) begin
            @(posedge clk); #1;
            chk("cfg_err single pulse", cfg_err, 1'b0);
        end
    endtask

    task automatic set_weights(input logic [W-1:0] v);
        for (int n = 0; n < NO; n++)
            for (int i = 0; i < NI; i++)
                cfg_write(n*(NI+1) + i, v, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int hs, hs2;
        repeat (3) @(posedge clk);
        #1;
        chk("reset values_out", values_out, '0);
        chk("reset valid_out", valid_out, 1'b0);
        chk("reset overflow", overflow, 1'b0);
        chk("reset cfg_err", cfg_err, 1'b0);
        @(negedge clk) rstn = 1'b1;
        #1 chk("ready after reset", ready, 1'b1);
        @(posedge clk); #1;

        // Unity weights: 8*1 + 16*1 + 4*1 in Q3 -> 28 (3.5).
        set_weights(8'd8);
        frame(8'd8, 8'd16, 8'd4, 1'b1, rep(8'd28), 1'b0);
        wait_idle();

        // Write during COMPUTE is dropped; a re-run gives the same result.
        frame(8'd8, 8'd16, 8'd4, 1'b1, rep(8'd28), 1'b0);
        chk("ready in COMPUTE", ready, 1'b0);
        cfg_write(0, 8'd99, 1'b1);
        wait_idle();
        frame(8'd8, 8'd16, 8'd4, 1'b1, rep(8'd28), 1'b0);
        wait_idle();
        cfg_write(20, 8'd5, 1'b1);

        // valid_in held through COMPUTE: nothing consumed until after DONE.
        send_sample(8'd8, hs);
        send_sample(8'd16, hs);
        send_sample(8'd4, hs);
        begin
            exp_t e;
            e.vals = rep(8'd28); e.ovf = 1'b0; e.at = hs + LAT;
            sb.push_back(e);
        end
        value_in = 8'd8;
        repeat (4) begin
            @(negedge clk);
            chk("ready low with valid_in held", ready, 1'b0);
        end
        send_sample(8'd8, hs2);
        chk("held sample accept cycle", hs2, hs + LAT + 2);
        send_sample(8'd16, hs);
        send_sample(8'd4, hs);
        valid_in = 1'b0;
        begin
            exp_t e;
            e.vals = rep(8'd28); e.ovf = 1'b0; e.at = hs + LAT;
            sb.push_back(e);
        end
        wait_idle();

        // 127*127*3 = 48387, >>>3 = 6048 = 0x17A0: wraps to 0xA0 or clamps.
        set_weights(8'd127);
`ifdef HIDDEN_LAYER_SATURATE_EN
        frame(8'd127, 8'd127, 8'd127, 1'b1, rep(8'd127), 1'b1);
`else
        frame(8'd127, 8'd127, 8'd127, 1'b1, rep(8'hA0), 1'b1);
`endif
        wait_idle();
        frame(8'd0, 8'd0, 8'd0, 1'b1, rep(8'd0), 1'b0);
        wait_idle();
`ifdef HIDDEN_LAYER_SATURATE_EN
        frame(8'd127, 8'd127, 8'd127, 1'b1, rep(8'd127), 1'b1);
`else
        frame(8'd127, 8'd127, 8'd127, 1'b1, rep(8'hA0), 1'b1);
`endif
        wait_idle();

        // Reset mid-COMPUTE clears everything including the weights.
        frame(8'd1, 8'd1, 8'd1, 1'b0, '0, 1'b0);
        repeat (4) @(posedge clk);
        #1 rstn = 1'b0;
        #2;
        chk("mid-reset values_out", values_out, '0);
        chk("mid-reset overflow", overflow, 1'b0);
        chk("mid-reset valid_out", valid_out, 1'b0);
        @(negedge clk) rstn = 1'b1;
        #1 chk("ready after mid-reset", ready, 1'b1);
        @(posedge clk); #1;
        frame(8'd8, 8'd16, 8'd4, 1'b1, rep(8'd0), 1'b0);
        wait_idle();

        // Neuron 4 (lane 0 of the last pass): bias -8 alone -> -8.
        cfg_write(4*(NI+1) + NI, 8'hF8, 1'b0);
        frame(8'd8, 8'd16, 8'd4, 1'b1, {8'hF8, 32'h0}, 1'b0);
        wait_idle();
        // Bias 0, weight 4 (0.5) times input -1 (-0.125): -4/64 floors to -1.
        cfg_write(4*(NI+1) + NI, 8'h00, 1'b0);
        cfg_write(4*(NI+1) + 0, 8'd4, 1'b0);
        frame(8'hFF, 8'd0, 8'd0, 1'b1, {8'hFF, 32'h0}, 1'b0);
        wait_idle();

        repeat (5) @(posedge clk);
        chk("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/hidden_layer_tdm.md
# hidden_layer_tdm

Time-multiplexed fully-connected hidden layer. It is the parametrised successor of the per-neuron hidden layer: NUM_OUTPUTS neurons are evaluated by NUM_LANES shared multiply-accumulate lanes over several passes. Weights and biases are held locally and written over a parallel config port. It sits between the input streamer and the activation/output layer, and trades latency for multiplier count.

## Interface
- NUM_INPUTS, 4: inputs per frame (≥1)
- NUM_OUTPUTS, 8: neurons (≥1)
- NUM_LANES, 2: parallel MAC lanes (1..NUM_OUTPUTS)
- WIDTH, 8: signed fixed-point data width
- FRAC_BITS, 3: fractional bits
- CLK  in  1  clock, rising edge
- RSTN  in  1  asynchronous active-low reset
- CFG_WE  in  1  weight/bias write strobe
- CFG_ADDR  in  clog2(NUM_OUTPUTS*(NUM_INPUTS+1))  word address = n*(NUM_INPUTS+1)+i; i==NUM_INPUTS selects bias of neuron n
- CFG_WDATA  in  WIDTH  signed weight/bias
- CFG_ERR  out  1  one-cycle pulse: write dropped
- READY  out  1  input accept
- VALUE_IN  in  WIDTH  signed input sample
- VALID_IN  in  1  input qualifier
- VALUES_OUT  out  NUM_OUTPUTS*WIDTH  neuron n at [n*WIDTH +: WIDTH], registered, held
- VALID_OUT  out  1  one-cycle pulse: new VALUES_OUT frame
- OVERFLOW  out  1  at least one neuron of the last frame exceeded WIDTH range

## Operation
- States: LOAD → COMPUTE → DONE → LOAD.
- LOAD: READY=1; VALID_IN&READY stores VALUE_IN at input index k, k increments; on k==NUM_INPUTS-1 accepted → COMPUTE.
- COMPUTE: READY=0; P=ceil(NUM_OUTPUTS/NUM_LANES) passes, each NUM_INPUTS+2 cycles. Cycle 0: acc_j = bias<<FRAC_BITS. Cycles 1..NUM_INPUTS: acc_j += x[i]*w[n][i]. Last cycle: result of lane j written to output slot n=p*NUM_LANES+j. Lanes with n≥NUM_OUTPUTS are computed and discarded.
- DONE (1 cycle): VALUES_OUT updated from the result staging, VALID_OUT=1, OVERFLOW updated, → LOAD.
- Arithmetic: products are full 2*WIDTH with 2*FRAC_BITS fractional bits. Accumulator is 2*WIDTH+clog2(NUM_INPUTS+1) bits, so it never wraps. Result = acc >>> FRAC_BITS (arithmetic, floor). The result is out of range if it is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]; this sets the frame overflow flag.
- Config: writes are accepted in LOAD, including mid-frame. Writes in COMPUTE/DONE, or with CFG_ADDR out of range, are dropped and CFG_ERR pulses the next cycle.
- VALID_IN with READY=0 is not consumed; the upstream holds it.
- Reset (any state, including mid-COMPUTE): state=LOAD, k=0, all weights/biases=0, VALUES_OUT=0, VALID_OUT=0, OVERFLOW=0, CFG_ERR=0. READY=1 in the first cycle after RSTN deasserts.

## Timing
- Input: one sample per cycle at full rate in LOAD.
- Latency: the cycle after the last input handshake is COMPUTE cycle 0. VALID_OUT asserts P*(NUM_INPUTS+2)+1 cycles after that handshake.
- Throughput: one frame per NUM_INPUTS + P*(NUM_INPUTS+2) + 1 cycles.
- Config write takes effect on the next rising edge and is visible to the next COMPUTE.
- CFG_WE in the same cycle as the last input handshake is accepted; that state is still LOAD.
- OVERFLOW and VALUES_OUT change only in DONE. They hold between frames.

## Configuration
- HIDDEN_LAYER_SATURATE_EN defined: out-of-range results clamp to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
- Undefined: out-of-range results wrap (low WIDTH bits of the shifted accumulator).
- OVERFLOW reports the condition in both builds.

## Test plan
All scenarios use WIDTH=8, FRAC_BITS=3, NUM_INPUTS=3, NUM_OUTPUTS=5, NUM_LANES=2 (P=3).
- All weights 8 (1.0), biases 0, inputs 8,16,4 → all five outputs 28 (3.5); VALID_OUT exactly 16 cycles after the last input; OVERFLOW=0.
- All weights 127, inputs 127 ×3 → OVERFLOW=1; outputs 127 with HIDDEN_LAYER_SATURATE_EN, -96 without.
- Neuron 4 bias -8, weights 0; then weight 4, input -1 → output -8 (-1.0); with bias 0 the output is -1 (floor of -0.0625·… = -0.125); the non-final lane slot for neuron 5 is ignored.
- CFG_WE during COMPUTE to address 0 → CFG_ERR pulses once; a re-run returns the unchanged result; CFG_ADDR=20 in LOAD → CFG_ERR.
- VALID_IN held high through COMPUTE → READY=0, no sample consumed; the next frame's first sample is accepted in the cycle after DONE.
- RSTN low mid-COMPUTE → all outputs 0, READY=1 after release; the next frame with weights unset yields 0.
